// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// Serial front end for the single-port RAM. It turns MOSI frames into
// {cmd[1:0], byte[DATA_W-1:0]} words with a one-cycle rx_valid strobe. For
// read-data frames it waits for the RAM's tx_valid and shifts the returned byte
// out on MISO, MSB first. The SPI bit clock is clk itself: one bit is taken on
// every rising edge while SS_n is low.
//
// Ports
//   clk       in   1         system clock, all state on rising edge
//   rst_n     in   1         asynchronous active-low reset
//   SS_n      in   1         slave select, active low; high aborts any frame
//   MOSI      in   1         serial data in
//   MISO      out  1         serial data out, 0 when not shifting
//   rx_data   out  DATA_W+2  deserialised word to RAM din
//   rx_valid  out  1         one-cycle strobe, rx_data valid
//   tx_data   in   DATA_W    byte from RAM dout
//   tx_valid  in   1         RAM strobe, tx_data valid
// -----------------------------------------------------------------------------
module spi_slave_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // Index of the last received bit and the number of MISO bits left after the
  // MSB has been driven on the load edge.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(DATA_W - 1);

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;          // rx bit index, reused as tx bits-left count
  logic [DATA_W:0]     shift_r;        // first DATA_W+1 bits; the last comes straight from MOSI
  logic [DATA_W-2:0]   tx_shift_r;     // read byte minus the MSB already on MISO
  logic                rd_addr_done_r; // a read address has been sent, next read frame is data
  logic                rx_done_r;      // word of the current frame already delivered
  logic                tx_busy_r;      // MISO shifting in progress
  logic                tx_done_r;      // read byte fully shifted, hold until deselect

  // Frame FSM: deserialiser, read-byte serialiser and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      shift_r        <= '0;
      tx_shift_r     <= '0;
      rd_addr_done_r <= 1'b0;
      rx_done_r      <= 1'b0;
      tx_busy_r      <= 1'b0;
      tx_done_r      <= 1'b0;
      MISO           <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        // Deselect wins over everything, including a last-bit edge.
        state_r   <= IDLE;
        cnt_r     <= '0;
        MISO      <= 1'b0;
        rx_done_r <= 1'b0;
        tx_busy_r <= 1'b0;
        tx_done_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r   <= CHK_CMD;
            cnt_r     <= '0;
            rx_done_r <= 1'b0;
            tx_busy_r <= 1'b0;
            tx_done_r <= 1'b0;
          end
          CHK_CMD: begin
            cnt_r <= '0;
            if (!MOSI) begin
              state_r <= WRITE;
            end else if (rd_addr_done_r) begin
              state_r <= READ_DATA;
            end else begin
              state_r <= READ_ADD;
            end
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!rx_done_r) begin
              shift_r <= {shift_r[DATA_W-1:0], MOSI};
              if (cnt_r == LAST_BIT) begin
                rx_data   <= {shift_r, MOSI};
                rx_valid  <= 1'b1;
                rx_done_r <= 1'b1;
                cnt_r     <= '0;
                if (state_r == READ_ADD) begin
                  rd_addr_done_r <= 1'b1;
                end
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end else if (state_r == READ_DATA) begin
              if (tx_busy_r) begin
                if (cnt_r != '0) begin
                  MISO       <= tx_shift_r[DATA_W-2];
                  tx_shift_r <= {tx_shift_r[DATA_W-3:0], 1'b0};
                  cnt_r      <= cnt_r - CNT_W'(1);
                end else begin
                  // Edge after bit 0: byte complete, the read pair is consumed.
                  MISO           <= 1'b0;
                  tx_busy_r      <= 1'b0;
                  tx_done_r      <= 1'b1;
                  rd_addr_done_r <= 1'b0;
                end
              end else if (!tx_done_r && tx_valid) begin
                MISO       <= tx_data[DATA_W-1];
                tx_shift_r <= tx_data[DATA_W-2:0];
                cnt_r      <= TX_LAST;
                tx_busy_r  <= 1'b1;
              end else begin
                MISO <= 1'b0;
              end
            end else begin
              MISO <= 1'b0;
            end
          end
          default: begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            MISO      <= 1'b0;
            rx_done_r <= 1'b0;
            tx_busy_r <= 1'b0;
            tx_done_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_if
// Frame-level bench for spi_slave_if. Each frame is described by its command
// bit, 10-bit word, abort point, RAM response delay and returned byte; the
// expected rx_valid/rx_data/MISO per edge follow from those numbers and a
// single bench-side "read address pending" flag.
// -----------------------------------------------------------------------------
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int total = 0;
  int bad   = 0;
  bit rdd   = 1'b0;  // reference: a read address is pending

  spi_slave_if #(.DATA_W(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One deselected edge, outputs must be quiet.
  task automatic idle_edge();
    SS_n     = 1'b1;
    MOSI     = 1'($urandom);
    tx_valid = 1'($urandom);
    tx_data  = 8'($urandom);
    @(posedge clk); #1;
    chk("idle_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("idle_miso", {31'd0, MISO}, 32'd0);
  endtask

  // Frame: edge 0 selects, edge 1 carries cmd, edges 2..11 carry word[9..0].
  // abort_at = k (0..9): SS_n high from the edge that would take bit k+1.
  // d = 0: RAM never answers; d > 0: tx_valid sampled at edge 12+d.
  // rst_at >= 0: async reset pulled mid-cycle after that edge's checks.
  task automatic frame(input logic cmd, input logic [9:0] word, input int abort_at,
                       input int d, input logic [7:0] tx_byte, input int rst_at);
    bit rd_frame;
    bit aborted;
    int t_edge;
    int last;
    bit exp_rv;
    logic exp_miso;
    rd_frame = cmd && rdd;
    aborted  = (abort_at >= 0) && (abort_at < 10);
    t_edge   = (rd_frame && !aborted && d > 0) ? 12 + d : -1;
    last     = (t_edge >= 0) ? t_edge + 10 : 27;
    for (int e = 0; e <= last; e++) begin
      SS_n = (aborted && e >= abort_at + 2) ? 1'b1 : 1'b0;
      if (e == 1) MOSI = cmd;
      else if (e >= 2 && e <= 11) MOSI = word[11-e];
      else MOSI = 1'($urandom);
      if (e == t_edge) begin
        tx_valid = 1'b1;
        tx_data  = tx_byte;
      end else if (rd_frame && !aborted && e >= 12 && (t_edge < 0 || e < t_edge)) begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = 1'($urandom);
        tx_data  = 8'($urandom);
      end
      @(posedge clk); #1;
      exp_rv   = !aborted && (e == 11);
      exp_miso = (t_edge >= 0 && e >= t_edge && e <= t_edge + 7) ? tx_byte[7-(e-t_edge)] : 1'b0;
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_rv});
      chk("miso", {31'd0, MISO}, {31'd0, exp_miso});
      if (exp_rv) chk("rx_data", {22'd0, rx_data}, {22'd0, word});
      if (e == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_miso", {31'd0, MISO}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        SS_n  = 1'b1;
        rdd   = 1'b0;
        return;
      end
    end
    if (!aborted) begin
      if (cmd && !rdd) rdd = 1'b1;
      else if (rd_frame && t_edge >= 0) rdd = 1'b0;
    end
    idle_edge();
  endtask

  initial begin
    // Reset state while rst_n held low.
    #12;
    chk("reset_miso", {31'd0, MISO}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_rx_data", {22'd0, rx_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_edge();

    // Write address then write data.
    frame(1'b0, 10'h02A, -1, 0, 8'h00, -1);
    frame(1'b0, 10'h15C, -1, 0, 8'h00, -1);
    // Read address, then read data with RAM returning 0x5C one cycle later.
    frame(1'b1, 10'h22A, -1, 0, 8'h00, -1);
    frame(1'b1, 10'h300, -1, 1, 8'h5C, -1);
    // Abort after 5 bits, then a clean frame.
    frame(1'b0, 10'h3FF, 5, 0, 8'h00, -1);
    frame(1'b0, 10'h0A5, -1, 0, 8'h00, -1);
    // Read command with no pending address decodes as read address.
    frame(1'b1, 10'h311, -1, 0, 8'h00, -1);
    // Late RAM answer.
    frame(1'b1, 10'h300, -1, 20, 8'hA7, -1);
    // Deselect on the last-bit edge discards the frame.
    frame(1'b0, 10'h2F0, 9, 0, 8'h00, -1);
    // Read-data frame with no RAM answer keeps the pending address.
    frame(1'b1, 10'h1AB, -1, 0, 8'h00, -1);
    frame(1'b1, 10'h3C3, -1, 0, 8'h00, -1);
    frame(1'b1, 10'h3C3, -1, 2, 8'h96, -1);
    // Reset while rx_valid is high, then reset mid MISO shift.
    frame(1'b1, 10'h055, -1, 0, 8'h00, 11);
    frame(1'b1, 10'h155, -1, 0, 8'h00, -1);
    frame(1'b1, 10'h255, -1, 1, 8'hFF, 14);
    idle_edge();

    // Randomised frames.
    for (int n = 0; n < 60; n++) begin
      logic       cmd;
      logic [9:0] word;
      int         ab;
      int         d;
      cmd  = 1'($urandom);
      word = 10'($urandom);
      ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
      d    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4));
      frame(cmd, word, ab, d, 8'($urandom), -1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
